seq_pattern_matcher: RTL and testbench

//  Programmable, parametrised successor to the fixed input-sequence detector FSM.

---
 rtl/seq_pattern_matcher.sv | 169 ++++++++++++++++
 tb/tb_seq_pattern_matcher.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_matcher.sv
// Programmable sequence detector: walks a sample vector through a mask/value step table,
// reporting detect, mid-pattern timeout and a saturating match count.
module seq_pattern_matcher #(
    parameter int IN_W      = 4,
    parameter int MAX_STEPS = 16,
    parameter int TIMEOUT   = 1023,
    parameter int CNT_W     = 8,
    parameter int STICKY    = 1,
    localparam int AW       = $clog2(MAX_STEPS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             sample_valid_i,
    input  logic [IN_W-1:0]  sample_i,
    input  logic             cfg_we_i,
    input  logic [AW-1:0]    cfg_addr_i,
    input  logic [IN_W-1:0]  cfg_mask_i,
    input  logic [IN_W-1:0]  cfg_value_i,
    input  logic             cfg_len_we_i,
    input  logic [AW:0]      cfg_len_i,
    input  logic             ack_i,
    output logic [AW-1:0]    step_o,
    output logic             busy_o,
    output logic             detect_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             cfg_err_o,
    output logic [CNT_W-1:0] match_count_o
);

    localparam int              TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [AW:0]     LEN_MAX = (AW+1)'(MAX_STEPS);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    step_q, step_d;
    logic [TO_W-1:0]  idle_q, idle_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AW:0]      len_q, len_in;
    logic             detect_q, detect_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             cfg_err_q, cfg_err_d;
    logic             busy_q;
    logic             fire;
    logic             hit_cur, hit_first, at_last, len_one;

    logic [IN_W-1:0]  mask_q  [MAX_STEPS];
    logic [IN_W-1:0]  value_q [MAX_STEPS];

    assign hit_cur   = ((sample_i ^ value_q[step_q]) & mask_q[step_q]) == '0;
    assign hit_first = ((sample_i ^ value_q[0]) & mask_q[0]) == '0;
    assign at_last   = {1'b0, step_q} == (len_q - (AW+1)'(1));
    assign len_one   = len_q == (AW+1)'(1);

    always_comb begin
        len_in = cfg_len_i;
        if (cfg_len_i == '0) begin
            len_in = (AW+1)'(1);
        end else if (cfg_len_i > LEN_MAX) begin
            len_in = LEN_MAX;
        end
    end

    // IDLE with enable high is treated as running, so the first enabled sample is evaluated.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        idle_d    = idle_q;
        count_d   = count_q;
        detect_d  = 1'b0;
        timeout_d = 1'b0;
        fire      = 1'b0;
        cfg_err_d = enable_i && (cfg_we_i || cfg_len_we_i);
        if (!enable_i) begin
            state_d = S_IDLE;
            step_d  = '0;
            idle_d  = '0;
        end else if (state_q == S_DONE) begin
            idle_d = '0;
            if (ack_i) begin
                state_d = S_RUN;
                step_d  = '0;
            end
        end else begin
            state_d = S_RUN;
            if (sample_valid_i) begin
                idle_d = '0;
                if (hit_cur) begin
                    if (at_last) fire = 1'b1;
                    else         step_d = step_q + AW'(1);
                end else if (step_q != '0 && hit_first) begin
                    // restart: the rejected sample may itself open a new attempt
                    if (len_one) fire = 1'b1;
                    else         step_d = AW'(1);
                end else begin
                    step_d = '0;
                end
            end else if (TIMEOUT != 0 && step_q != '0) begin
                if (idle_q == TO_LAST) begin
                    step_d    = '0;
                    idle_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end else begin
                idle_d = '0;
            end
            if (fire) begin
                detect_d = 1'b1;
                step_d   = '0;
                if (count_q != '1) count_d = count_q + CNT_W'(1);
                if (STICKY != 0) state_d = S_DONE;
            end
        end
        done_d = state_d == S_DONE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < MAX_STEPS; i++) begin
                mask_q[i]  <= '0;
                value_q[i] <= '0;
            end
        end else if (!enable_i && cfg_we_i) begin
            mask_q[cfg_addr_i]  <= cfg_mask_i;
            value_q[cfg_addr_i] <= cfg_value_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            idle_q    <= '0;
            count_q   <= '0;
            len_q     <= (AW+1)'(1);
            detect_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            idle_q    <= idle_d;
            count_q   <= count_d;
            detect_q  <= detect_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cfg_err_q <= cfg_err_d;
            busy_q    <= step_d != '0;
            if (!enable_i && cfg_len_we_i) len_q <= len_in;
        end
    end

    assign step_o        = step_q;
    assign busy_o        = busy_q;
    assign detect_o      = detect_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign cfg_err_o     = cfg_err_q;
    assign match_count_o = count_q;

endmodule

// File: tb/tb_seq_pattern_matcher.sv
// Scoreboard bench: three matcher variants share one stimulus stream; expected outputs
// are queued per clock edge and a monitor compares them after each edge.
module tb_seq_pattern_matcher;

    localparam int SA = 0;  // TIMEOUT=5, sticky, 8-bit count
    localparam int SB = 1;  // timeout disabled, sticky
    localparam int SC = 2;  // TIMEOUT=5, auto-restart, 2-bit count

    logic       clk, reset, enable, sample_valid, ack, cfg_we, cfg_len_we;
    logic [3:0] sample, cfg_addr, cfg_mask, cfg_value;
    logic [4:0] cfg_len;

    logic [3:0] a_step, b_step, c_step;
    logic       a_busy, a_det, a_done, a_to, a_err;
    logic       b_busy, b_det, b_done, b_to, b_err;
    logic       c_busy, c_det, c_done, c_to, c_err;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;

    seq_pattern_matcher #(.TIMEOUT(5), .STICKY(1), .CNT_W(8)) dut_a (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .sample_valid_i(sample_valid),
        .sample_i(sample), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_mask_i(cfg_mask),
        .cfg_value_i(cfg_value), .cfg_len_we_i(cfg_len_we), .cfg_len_i(cfg_len), .ack_i(ack),
        .step_o(a_step), .busy_o(a_busy), .detect_o(a_det), .done_o(a_done),
        .timeout_o(a_to), .cfg_err_o(a_err), .match_count_o(a_cnt));

    seq_pattern_matcher #(.TIMEOUT(0), .STICKY(1), .CNT_W(8)) dut_b (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .sample_valid_i(sample_valid),
        .sample_i(sample), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_mask_i(cfg_mask),
        .cfg_value_i(cfg_value), .cfg_len_we_i(cfg_len_we), .cfg_len_i(cfg_len), .ack_i(ack),
        .step_o(b_step), .busy_o(b_busy), .detect_o(b_det), .done_o(b_done),
        .timeout_o(b_to), .cfg_err_o(b_err), .match_count_o(b_cnt));

    seq_pattern_matcher #(.TIMEOUT(5), .STICKY(0), .CNT_W(2)) dut_c (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .sample_valid_i(sample_valid),
        .sample_i(sample), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_mask_i(cfg_mask),
        .cfg_value_i(cfg_value), .cfg_len_we_i(cfg_len_we), .cfg_len_i(cfg_len), .ack_i(ack),
        .step_o(c_step), .busy_o(c_busy), .detect_o(c_det), .done_o(c_done),
        .timeout_o(c_to), .cfg_err_o(c_err), .match_count_o(c_cnt));

    typedef struct {
        int          cyc;
        int          sel;
        string       name;
        logic [16:0] v;
    } exp_t;

    exp_t q[$];
    int   stim_cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] actual(input int sel);
        if (sel == SA) return {a_step, a_busy, a_det, a_done, a_to, a_err, a_cnt};
        if (sel == SB) return {b_step, b_busy, b_det, b_done, b_to, b_err, b_cnt};
        return {c_step, c_busy, c_det, c_done, c_to, c_err, 6'b0, c_cnt};
    endfunction

    // monitor: one pass per rising edge, comparing every expectation tagged for that edge
    initial begin
        int mon_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc <= mon_cyc) begin
                exp_t e;
                logic [16:0] got;
                e   = q.pop_front();
                got = actual(e.sel);
                n_vec++;
                if (got !== e.v || e.cyc != mon_cyc) begin
                    n_bad++;
                    $display("FAIL %s (dut %0d, cyc %0d): got step=%0d busy=%b det=%b done=%b to=%b err=%b cnt=%0d, want step=%0d busy=%b det=%b done=%b to=%b err=%b cnt=%0d",
                             e.name, e.sel, mon_cyc, got[16:13], got[12], got[11], got[10], got[9], got[8], got[7:0],
                             e.v[16:13], e.v[12], e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
                end else begin
                    $display("ok   %s (dut %0d, cyc %0d): step=%0d det=%b done=%b to=%b err=%b cnt=%0d",
                             e.name, e.sel, mon_cyc, got[16:13], got[11], got[10], got[9], got[8], got[7:0]);
                end
            end
            mon_cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic drv(input logic en, input logic sv, input logic [3:0] smp, input logic ak);
        enable       = en;
        sample_valid = sv;
        sample       = smp;
        ack          = ak;
        cfg_we       = 1'b0;
        cfg_len_we   = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] m, input logic [3:0] v);
        drv(1'b0, 1'b0, 4'h0, 1'b0);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_mask  = m;
        cfg_value = v;
    endtask

    task automatic ex(input int sel, input string nm, input logic [3:0] st, input logic det,
                      input logic dn, input logic to, input logic err, input logic [7:0] cnt);
        exp_t e;
        e.cyc  = stim_cyc;
        e.sel  = sel;
        e.name = nm;
        e.v    = {st, st != 4'd0, det, dn, to, err, cnt};
        q.push_back(e);
    endtask

    task automatic tick();
        stim_cyc++;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        cfg_addr = '0; cfg_mask = '0; cfg_value = '0; cfg_len = '0;
        drv(0, 0, 4'h0, 0);
        tick();
        ex(SA, "rst", 4'd0, 0, 0, 0, 0, 8'd0);
        ex(SC, "rst_c", 4'd0, 0, 0, 0, 0, 8'd0);
        tick();
        reset = 1'b0;

        // defaults: len 1, mask 0 -> any sample detects
        drv(1, 1, 4'h5, 0); ex(SA, "dflt_det", 4'd0, 1, 1, 0, 0, 8'd1);
        ex(SC, "dflt_det_c", 4'd0, 1, 0, 0, 0, 8'd1); tick();
        drv(1, 1, 4'h5, 0); ex(SA, "done_ignores", 4'd0, 0, 1, 0, 0, 8'd1); tick();
        drv(1, 0, 4'h0, 1); ex(SA, "dflt_ack", 4'd0, 0, 0, 0, 0, 8'd1); tick();

        // 4-step pattern 8,A,1,F; last entry and length written in the same cycle
        wr(4'd0, 4'hF, 4'h8); ex(SA, "cfg_no_err", 4'd0, 0, 0, 0, 0, 8'd1); tick();
        wr(4'd1, 4'hF, 4'hA); tick();
        wr(4'd2, 4'hF, 4'h1); tick();
        wr(4'd3, 4'hF, 4'hF); cfg_len_we = 1'b1; cfg_len = 5'd4; tick();
        drv(1, 1, 4'h8, 0); ex(SA, "p4_s1", 4'd1, 0, 0, 0, 0, 8'd1); tick();
        drv(1, 1, 4'hA, 0); ex(SA, "p4_s2", 4'd2, 0, 0, 0, 0, 8'd1); tick();
        drv(1, 1, 4'h1, 0); ex(SA, "p4_s3", 4'd3, 0, 0, 0, 0, 8'd1); tick();
        drv(1, 1, 4'hF, 0); ex(SA, "p4_det", 4'd0, 1, 1, 0, 0, 8'd2);
        ex(SC, "p4_det_c", 4'd0, 1, 0, 0, 0, 8'd3); tick();
        drv(1, 1, 4'h8, 0); ex(SA, "p4_done_hold", 4'd0, 0, 1, 0, 0, 8'd2); tick();
        drv(1, 0, 4'h0, 1); ex(SA, "p4_ack", 4'd0, 0, 0, 0, 0, 8'd2); tick();
        drv(1, 1, 4'h3, 0); ex(SA, "s0_miss", 4'd0, 0, 0, 0, 0, 8'd2); tick();
        drv(1, 1, 4'h8, 0); ex(SA, "k1_enter", 4'd1, 0, 0, 0, 0, 8'd2); tick();
        drv(1, 1, 4'h7, 0); ex(SA, "k1_miss", 4'd0, 0, 0, 0, 0, 8'd2); tick();

        // restart: pattern 5,9,(1100 masked C); feed 5,5,9,D
        wr(4'd0, 4'hF, 4'h5); ex(SA, "disabled", 4'd0, 0, 0, 0, 0, 8'd2); tick();
        wr(4'd1, 4'hF, 4'h9); tick();
        wr(4'd2, 4'hC, 4'hC); cfg_len_we = 1'b1; cfg_len = 5'd3; tick();
        drv(1, 1, 4'h5, 0); ex(SA, "ov_s1", 4'd1, 0, 0, 0, 0, 8'd2); tick();
        drv(1, 1, 4'h5, 0); ex(SA, "ov_rematch", 4'd1, 0, 0, 0, 0, 8'd2); tick();
        drv(1, 1, 4'h9, 0); ex(SA, "ov_s2", 4'd2, 0, 0, 0, 0, 8'd2); tick();
        drv(1, 1, 4'hD, 0); ex(SA, "ov_det_masked", 4'd0, 1, 1, 0, 0, 8'd3); tick();
        drv(1, 0, 4'h0, 1); ex(SA, "ov_ack", 4'd0, 0, 0, 0, 0, 8'd3); tick();

        // timeout: A aborts after 5 idle cycles, B (disabled) holds step 2
        drv(1, 1, 4'h5, 0); ex(SA, "to_s1", 4'd1, 0, 0, 0, 0, 8'd3); tick();
        drv(1, 1, 4'h9, 0); ex(SA, "to_s2", 4'd2, 0, 0, 0, 0, 8'd3); tick();
        for (int i = 1; i <= 100; i++) begin
            drv(1, 0, 4'h0, 0);
            if (i < 5)       ex(SA, "to_wait", 4'd2, 0, 0, 0, 0, 8'd3);
            else if (i == 5) ex(SA, "to_pulse", 4'd0, 0, 0, 1, 0, 8'd3);
            else if (i == 6) ex(SA, "to_clear", 4'd0, 0, 0, 0, 0, 8'd3);
            if (i == 5 || i % 25 == 0) ex(SB, "no_timeout", 4'd2, 0, 0, 0, 0, 8'd3);
            tick();
        end

        // config guard while enabled
        drv(1, 0, 4'h0, 0); cfg_we = 1'b1; cfg_addr = 4'd0; cfg_mask = 4'hF; cfg_value = 4'h0;
        ex(SA, "guard_we", 4'd0, 0, 0, 0, 1, 8'd3); tick();
        drv(1, 0, 4'h0, 0); cfg_len_we = 1'b1; cfg_len = 5'd1;
        ex(SA, "guard_len", 4'd0, 0, 0, 0, 1, 8'd3); tick();
        drv(1, 1, 4'h5, 0); ex(SA, "guard_tbl_kept", 4'd1, 0, 0, 0, 0, 8'd3); tick();
        drv(1, 1, 4'h9, 0); ex(SA, "guard_len_kept", 4'd2, 0, 0, 0, 0, 8'd3); tick();
        drv(1, 1, 4'hD, 0); ex(SA, "guard_det", 4'd0, 1, 1, 0, 0, 8'd4); tick();

        // enable drop out of DONE, and length 0 stored as 1
        drv(0, 0, 4'h0, 0); cfg_len_we = 1'b1; cfg_len = 5'd0;
        ex(SA, "dis_from_done", 4'd0, 0, 0, 0, 0, 8'd4); tick();
        drv(1, 1, 4'h5, 0); ex(SA, "len0_as_1", 4'd0, 1, 1, 0, 0, 8'd5); tick();
        drv(1, 0, 4'h0, 1); ex(SA, "len0_ack", 4'd0, 0, 0, 0, 0, 8'd5); tick();
        drv(1, 1, 4'h3, 0); ex(SA, "len1_miss", 4'd0, 0, 0, 0, 0, 8'd5); tick();

        // length 31 clamps to 16
        wr(4'd1, 4'h0, 4'h0); tick();
        wr(4'd2, 4'h0, 4'h0); tick();
        wr(4'd3, 4'h0, 4'h0); cfg_len_we = 1'b1; cfg_len = 5'd31; tick();
        for (int i = 0; i < 16; i++) begin
            drv(1, 1, (i == 0) ? 4'h5 : 4'(i), 0);
            if (i == 0)  ex(SA, "len16_s1", 4'd1, 0, 0, 0, 0, 8'd5);
            if (i == 14) ex(SA, "len16_s15", 4'd15, 0, 0, 0, 0, 8'd5);
            if (i == 15) ex(SA, "len16_det", 4'd0, 1, 1, 0, 0, 8'd6);
            tick();
        end

        // saturation and mid-pattern enable drop
        reset = 1'b1; drv(0, 0, 4'h0, 0); tick();
        ex(SA, "rst2", 4'd0, 0, 0, 0, 0, 8'd0); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 4'h6, 0);
            ex(SC, "sat", 4'd0, 1, 0, 0, 0, (i < 3) ? 8'(i + 1) : 8'd3);
            tick();
        end
        drv(0, 0, 4'h0, 0); cfg_len_we = 1'b1; cfg_len = 5'd4;
        ex(SC, "sat_hold", 4'd0, 0, 0, 0, 0, 8'd3); tick();
        for (int i = 1; i <= 3; i++) begin
            drv(1, 1, 4'h6, 0);
            if (i == 3) begin
                ex(SC, "mid_s3", 4'd3, 0, 0, 0, 0, 8'd3);
                ex(SA, "mid_s3_a", 4'd3, 0, 0, 0, 0, 8'd1);
            end
            tick();
        end
        drv(0, 0, 4'h0, 0);
        ex(SC, "mid_drop", 4'd0, 0, 0, 0, 0, 8'd3);
        ex(SA, "mid_drop_a", 4'd0, 0, 0, 0, 0, 8'd1); tick();
        tick();
        tick();

        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
